// File: rtl/count_sequencer.sv
// Round sequencer for the loadable up-counter: loads init_q, enables the counter
// until its carry-out fires, and repeats for rounds_q rounds before pulsing done.
`timescale 1ns/1ps
module count_sequencer #(
  parameter int N  = 6,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  init_val,
  input  logic [RW-1:0] rounds,
  input  logic          co,
  output logic          cnt_ld,
  output logic          cnt_en,
  output logic [N-1:0]  cnt_init,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] round_idx
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [N-1:0]  init_q, init_d;
  logic [RW-1:0] rounds_q, rounds_d;
  logic [RW-1:0] idx_q, idx_d;
  logic [RW-1:0] idx_inc;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    init_d   = init_q;
    rounds_d = rounds_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          init_d   = init_val;
          rounds_d = rounds;
          idx_d    = '0;
          state_d  = (rounds == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        // Abort outranks a simultaneous carry-out: the round is not credited.
        if (abort) begin
          state_d = S_IDLE;
        end else if (co) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == rounds_q) ? S_DONE : S_GAP;
        end
      end
      S_GAP:  state_d = abort ? S_IDLE : S_LOAD;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      init_q   <= '0;
      rounds_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      rounds_q <= rounds_d;
      idx_q    <= idx_d;
    end
  end

  // Enable drops in the same cycle co rises so the counter parks at all-ones.
  assign cnt_ld    = (state_q == S_LOAD);
  assign cnt_en    = (state_q == S_RUN) && !co;
  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign cnt_init  = init_q;
  assign round_idx = idx_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer with a behavioural model of the downstream counter;
// expected timing comes from the round-length formulas, results via a scoreboard queue.
`timescale 1ns/1ps
module tb_count_sequencer;
  localparam int N  = 6;
  localparam int RW = 4;
  localparam int M  = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [N-1:0]  init_val;
  logic [RW-1:0] rounds;
  logic          co;
  logic          cnt_ld, cnt_en, busy, done;
  logic [N-1:0]  cnt_init;
  logic [RW-1:0] round_idx;
  logic [N-1:0]  cnt_m = '0;

  typedef struct {
    int            done_cyc;
    logic [RW-1:0] idx;
  } exp_t;
  exp_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  count_sequencer #(.N(N), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .init_val(init_val), .rounds(rounds), .co(co),
    .cnt_ld(cnt_ld), .cnt_en(cnt_en), .cnt_init(cnt_init),
    .busy(busy), .done(done), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_ld)      cnt_m <= cnt_init;
    else if (cnt_en) cnt_m <= cnt_m + 1'b1;
  end
  assign co = &cnt_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Complete operation; leaves the bench in the IDLE cycle after DONE.
  task automatic run_op(input int v, input int r, input string tag);
    int   p, d;
    bit   seen;
    exp_t e;
    p = M - v + 3;
    d = (r == 0) ? 1 : r * p;
    e.done_cyc = d;
    e.idx      = RW'(r);
    exp_q.push_back(e);
    init_val = N'(v);
    rounds   = RW'(r);
    start    = 1'b1;
    step();
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 1; k <= d + 4 && !seen; k++) begin
      int ph;
      ph = (k - 1) % p;
      check($sformatf("%s.ld@%0d", tag, k), cnt_ld, (k < d) && (ph == 0));
      check($sformatf("%s.en@%0d", tag, k), cnt_en, (k < d) && (ph >= 1) && (ph <= M - v));
      check($sformatf("%s.busy@%0d", tag, k), busy, k < d);
      if (done === 1'b1) begin
        e = exp_q.pop_front();
        check({tag, ".done_cycle"}, k, e.done_cyc);
        check({tag, ".round_idx"}, round_idx, e.idx);
        seen = 1'b1;
      end else begin
        step();
      end
    end
    check({tag, ".done_seen"}, seen, 1);
    if (!seen) void'(exp_q.pop_front());
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; init_val = '0; rounds = '0;
    step();
    check("rst.cnt_ld", cnt_ld, 0);
    check("rst.cnt_en", cnt_en, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.round_idx", round_idx, 0);
    check("rst.cnt_init", cnt_init, 0);
    rst = 1'b0;
    step();

    run_op(60, 2, "basic");
    run_op(60, 0, "zero_rounds");
    run_op(63, 3, "init_max");
    run_op(0, 1, "init_zero");
    run_op(62, 15, "max_rounds");

    // Abort in the third RUN cycle of round 1.
    init_val = 6'd50; rounds = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("abort.busy_before", busy, 1);
    check("abort.en_before", cnt_en, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort.busy_after", busy, 0);
    check("abort.idx_after", round_idx, 0);
    check("abort.ld_after", cnt_ld, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort.no_done%0d", i), done, 0);
      step();
    end
    run_op(62, 2, "after_abort");

    // Abort coincident with co in RUN: no round credited.
    init_val = 6'd63; rounds = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("abort_co.co", co, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_co.busy", busy, 0);
    check("abort_co.idx", round_idx, 0);
    check("abort_co.done", done, 0);

    // Start held high: one capture per operation, restart right after DONE.
    init_val = 6'd61; rounds = 4'd1; start = 1'b1;
    step();
    check("hold.ld1", cnt_ld, 1);
    check("hold.init1", cnt_init, 61);
    init_val = 6'd55; rounds = 4'd3;
    step(); step(); step();
    check("hold.en_last_run", cnt_en, 0);
    step();
    check("hold.done", done, 1);
    check("hold.idx1", round_idx, 1);
    step();
    check("hold.idle_busy", busy, 0);
    check("hold.idle_done", done, 0);
    step();
    check("hold.ld2", cnt_ld, 1);
    check("hold.init2", cnt_init, 55);
    check("hold.idx_cleared", round_idx, 0);
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check("hold.aborted", busy, 0);

    // Asynchronous reset between edges during RUN of round 2.
    init_val = 6'd62; rounds = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("arst.en_before", cnt_en, 1);
    check("arst.idx_before", round_idx, 1);
    #2 rst = 1'b1;
    #1;
    check("arst.cnt_en", cnt_en, 0);
    check("arst.cnt_ld", cnt_ld, 0);
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    check("arst.round_idx", round_idx, 0);
    check("arst.cnt_init", cnt_init, 0);
    #1 rst = 1'b0;
    step();
    check("arst.idle_busy", busy, 0);
    check("arst.idle_done", done, 0);
    run_op(60, 2, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
